// File: rtl/glitch_gen_pkg.sv
// Shared types for the self-test glitch generator: FSM states, latched
// sequence configuration and the minimum-length helper.
package glitch_gen_pkg;

  localparam int GG_WIDTH = 4;   // driven lines
  localparam int GG_CNT_W = 8;   // delay/pulse/gap/repeat counter width
  localparam int MIN_LEN  = 1;   // zero-length fields behave as this

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    PULSE,
    GAP,
    DONE
  } gg_state_e;

  // Configuration captured on the accepted start edge.
  typedef struct packed {
    logic [GG_WIDTH-1:0] base;
    logic [GG_WIDTH-1:0] mask;
    logic [GG_CNT_W-1:0] delay;
    logic [GG_CNT_W-1:0] pulse_len;
    logic [GG_CNT_W-1:0] gap_len;
    logic [GG_CNT_W-1:0] repeat_n;
  } gg_cfg_t;

  // Counter reload value for an interval of max(len, MIN_LEN) cycles.
  function automatic logic [GG_CNT_W-1:0] len_m1(input logic [GG_CNT_W-1:0] len);
    len_m1 = (len <= GG_CNT_W'(MIN_LEN)) ? '0 : len - GG_CNT_W'(MIN_LEN);
  endfunction

endpackage

// File: rtl/glitch_generator_interval_counter.sv
// Loadable down-counter with a zero flag. Shared by the DELAY, PULSE and
// GAP intervals; load takes priority over decrement, and it holds at zero.
module interval_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Reload on interval entry, otherwise count down toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/glitch_generator.sv
// Programmable pulse-train source for analyzer capture-path self-test.
// The FSM state leads the registered outputs by one clock, which gives
// busy one cycle after start and the first pulse delay+1 cycles after it.
module glitch_generator
  import glitch_gen_pkg::*;
#(
  parameter int WIDTH = GG_WIDTH,  // must match GG_WIDTH (config struct sizing)
  parameter int CNT_W = GG_CNT_W   // must match GG_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] base_level,
  input  logic [WIDTH-1:0] lane_mask,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic [WIDTH-1:0] out_lines,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_count
);

  gg_state_e        state;
  gg_cfg_t          cfg;
  logic             go;
  logic             kill;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] rep_eff;
  logic [CNT_W:0]   next_pulses;
  logic             last_pulse;
  logic             delay_end;

  assign go          = (state == IDLE) && start && !abort;
  assign kill        = (state != IDLE) && abort;
  assign rep_eff     = (cfg.repeat_n == '0) ? CNT_W'(MIN_LEN) : cfg.repeat_n;
  assign next_pulses = {1'b0, pulse_count} + (CNT_W+1)'(1);
  assign last_pulse  = next_pulses >= {1'b0, rep_eff};
  // DELAY is only entered with a non-zero delay; the guard keeps a zero
  // latched delay from ever stalling there.
  assign delay_end   = cnt_zero || (cfg.delay == '0);

  interval_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Interval counter control: reload on each interval entry, else count.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state)
      IDLE: if (go) begin
        cnt_load = 1'b1;
        cnt_val  = (delay != '0) ? len_m1(delay) : len_m1(pulse_len);
      end
      DELAY: if (delay_end) begin
        cnt_load = 1'b1;
        cnt_val  = len_m1(cfg.pulse_len);
      end else cnt_dec = 1'b1;
      PULSE: if (cnt_zero) begin
        if (!last_pulse) begin
          cnt_load = 1'b1;
          cnt_val  = len_m1(cfg.gap_len);
        end
      end else cnt_dec = 1'b1;
      GAP: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = len_m1(cfg.pulse_len);
      end else cnt_dec = 1'b1;
      default: ;
    endcase
    if (kill) begin
      cnt_load = 1'b1;
      cnt_val  = '0;
    end
  end

  // Sequencer FSM plus registered output decode of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg         <= '0;
      out_lines   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        // Abort wins over everything: straight to idle, no done, keep count.
        state     <= IDLE;
        out_lines <= cfg.base;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cfg.base  <= base_level;
            out_lines <= base_level;
            busy      <= 1'b0;
            if (go) begin
              cfg <= '{base: base_level, mask: lane_mask, delay: delay,
                       pulse_len: pulse_len, gap_len: gap_len,
                       repeat_n: repeat_cnt};
              pulse_count <= '0;
              state       <= (delay != '0) ? DELAY : PULSE;
            end
          end
          DELAY: begin
            out_lines <= cfg.base;
            busy      <= 1'b1;
            if (delay_end) state <= PULSE;
          end
          PULSE: begin
            out_lines <= cfg.base ^ cfg.mask;
            busy      <= 1'b1;
            if (cnt_zero) begin
              if (pulse_count != '1) pulse_count <= pulse_count + CNT_W'(1);
              state <= last_pulse ? DONE : GAP;
            end
          end
          GAP: begin
            out_lines <= cfg.base;
            busy      <= 1'b1;
            if (cnt_zero) state <= PULSE;
          end
          DONE: begin
            out_lines <= cfg.base;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glitch_generator.sv
`timescale 1ns/1ps
// Self-checking bench for glitch_generator: directed and randomized
// sequences checked cycle by cycle against an expected-waveform model.
module tb_glitch_generator;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  base_level = '0;
  logic [W-1:0]  lane_mask = '0;
  logic [CW-1:0] delay = '0;
  logic [CW-1:0] pulse_len = '0;
  logic [CW-1:0] gap_len = '0;
  logic [CW-1:0] repeat_cnt = '0;
  logic [W-1:0]  out_lines;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulse_count;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] det_flags;
  logic [W-1:0] det_prev;

  glitch_generator #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .base_level  (base_level),
    .lane_mask   (lane_mask),
    .delay       (delay),
    .pulse_len   (pulse_len),
    .gap_len     (gap_len),
    .repeat_cnt  (repeat_cnt),
    .out_lines   (out_lines),
    .busy        (busy),
    .done        (done),
    .pulse_count (pulse_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Runs one sequence. The expected waveform is built up front as a list of
  // per-cycle line values following start: delay idle cycles, then pulses
  // separated by gaps, then a single done cycle. abort_at >= 0 aborts so
  // that the abort takes effect on that step. noise scrambles all inputs
  // (including start) while the sequence is busy.
  task automatic run_seq(input logic [W-1:0] b, input logic [W-1:0] m,
                         input int d, input int pl, input int gl, input int rp,
                         input int abort_at, input bit noise);
    logic [W-1:0] eo[$];
    int           nc[$];
    int           pe, ge, re;
    bit           aborted;
    pe = (pl < 1) ? 1 : pl;
    ge = (gl < 1) ? 1 : gl;
    re = (rp < 1) ? 1 : rp;
    aborted = 1'b0;
    for (int i = 0; i < d; i++) begin eo.push_back(b); nc.push_back(0); end
    for (int p = 0; p < re; p++) begin
      for (int i = 0; i < pe; i++) begin eo.push_back(b ^ m); nc.push_back(p); end
      if (p < re - 1)
        for (int i = 0; i < ge; i++) begin eo.push_back(b); nc.push_back(p + 1); end
    end

    @(negedge clk);
    base_level = b; lane_mask = m;
    delay = CW'(d); pulse_len = CW'(pl); gap_len = CW'(gl); repeat_cnt = CW'(rp);
    start = 1'b1;
    @(posedge clk);   // start edge
    @(negedge clk);
    start = 1'b0;
    chk("busy_at_start_edge", 32'(busy), 32'(0));
    det_prev  = out_lines;
    det_flags = '0;

    for (int k = 0; k < eo.size(); k++) begin
      if (noise) begin
        start      = 1'($urandom_range(0, 1));
        base_level = W'($urandom);
        lane_mask  = W'($urandom);
        delay      = CW'($urandom);
        pulse_len  = CW'($urandom);
        gap_len    = CW'($urandom);
        repeat_cnt = CW'($urandom);
      end
      if (k == abort_at) abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      det_flags = det_flags | (out_lines ^ det_prev);
      det_prev  = out_lines;
      if (k == abort_at) begin
        abort = 1'b0;
        chk("abort_out", 32'(out_lines), 32'(b));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_count", 32'(pulse_count), 32'(nc[k]));
        aborted = 1'b1;
        break;
      end
      chk("seq_out", 32'(out_lines), 32'(eo[k]));
      chk("seq_busy", 32'(busy), 32'(1));
      chk("seq_done", 32'(done), 32'(0));
    end

    start = 1'b0;
    base_level = b;
    if (!aborted) begin
      @(posedge clk);
      @(negedge clk);
      chk("done_out", 32'(out_lines), 32'(b));
      chk("done_busy", 32'(busy), 32'(0));
      chk("done_pulse", 32'(done), 32'(1));
      chk("done_count", 32'(pulse_count), 32'(re));
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_done", 32'(done), 32'(0));
      chk("post_busy", 32'(busy), 32'(0));
      chk("post_out", 32'(out_lines), 32'(b));
    end
  endtask

  initial begin
    // Reset defaults.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out_lines), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_count", 32'(pulse_count), 32'(0));
    rst = 1'b0;

    // Single pulse.
    run_seq(4'b0000, 4'b0001, 3, 2, 0, 1, -1, 1'b0);
    // Train of three.
    run_seq(4'b0101, 4'b1111, 0, 1, 2, 3, -1, 1'b0);
    // Zero lengths behave as 1/1/1, with start hammered while busy.
    run_seq(4'b1001, 4'b0110, 0, 0, 0, 0, -1, 1'b1);
    // Mask zero: timing and count run, lines never move.
    run_seq(4'b1100, 4'b0000, 2, 2, 1, 3, -1, 1'b0);
    chk("mask0_no_toggle", 32'(det_flags), 32'(0));
    // Abort in the middle of the second gap.
    run_seq(4'b0011, 4'b1100, 0, 1, 4, 5, 7, 1'b0);
    // Loopback edge detector sees only lane 2.
    run_seq(4'b0000, 4'b0100, 1, 1, 1, 2, -1, 1'b0);
    chk("loopback_lane2", 32'({4'b0000, det_flags}), 32'(8'h04));
    // Maximum counter values honoured exactly.
    run_seq(4'b0110, 4'b1001, 255, 255, 1, 2, -1, 1'b0);
    run_seq(4'b0001, 4'b1000, 0, 1, 1, 255, -1, 1'b0);

    // start and abort together in IDLE: nothing starts.
    @(negedge clk);
    base_level = 4'b0110; lane_mask = 4'b1111;
    delay = 8'd0; pulse_len = 8'd1; repeat_cnt = 8'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'(0));
    chk("start_abort_out", 32'(out_lines), 32'(4'b0110));
    @(posedge clk);
    @(negedge clk);
    chk("start_abort_busy2", 32'(busy), 32'(0));
    chk("start_abort_out2", 32'(out_lines), 32'(4'b0110));

    // Randomized sequences.
    for (int r = 0; r < 20; r++) begin
      run_seq(W'($urandom), W'($urandom), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 5)), -1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a train.
    @(negedge clk);
    base_level = 4'b0000; lane_mask = 4'b1111;
    delay = 8'd0; pulse_len = 8'd1; gap_len = 8'd1; repeat_cnt = 8'd8;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out_lines), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_done", 32'(done), 32'(0));
    chk("async_rst_count", 32'(pulse_count), 32'(0));
    base_level = 4'b1010;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_out", 32'(out_lines), 32'(4'b1010));
    chk("post_rst_busy", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
